// File: rtl/conv_pkg.sv
// Width helpers shared by the windowed multiply-accumulate and its history store.
package conv_pkg;

  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

  // Sum of DEPTH products needs log2(DEPTH) guard bits above the product width.
  function automatic int acc_w(input int data_w, input int depth);
    return 2 * data_w + $clog2(depth);
  endfunction

  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/conv_hist_ram.sv
// Per-channel product history: one registered read and one write per cycle.
// A read and a write to the same address in one cycle return the old contents.
module conv_hist_ram #(
  parameter int WIDTH   = 24,
  parameter int ENTRIES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       we,
  input  logic [$clog2(ENTRIES)-1:0] waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       re,
  input  logic [$clog2(ENTRIES)-1:0] raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  // Flop-based so that reset and clr can wipe every entry in a single edge.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// Per-channel sliding-window sum of A*B over the last DEPTH samples, time-multiplexed.
// Build option: define CONV_WINDOW_SAT_EN to clamp the output instead of wrapping it.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ch_w(CHANNELS)-1:0]     in_ch,
  input  logic signed [DATA_W-1:0]      A,
  input  logic signed [DATA_W-1:0]      B,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ch_w(CHANNELS)-1:0]     out_ch,
  output logic signed [OUT_W-1:0]       S,
  output logic                          out_primed
);

  localparam int PW   = prod_w(DATA_W);
  localparam int AW   = acc_w(DATA_W, DEPTH);
  localparam int CW   = ch_w(CHANNELS);
  localparam int PTRW = $clog2(DEPTH);
  localparam int FW   = PTRW + 1;
  localparam int RAW  = $clog2(CHANNELS * DEPTH);
  localparam int EW   = (AW > OUT_W) ? AW : OUT_W;

  logic stall, accept, ch_ok;

  // s0: captured operands; s1: product + evicted entry; then the output register
  logic                     s0_valid;
  logic signed [DATA_W-1:0] s0_a, s0_b;
  logic [CW-1:0]            s0_ch;

  logic                     s1_valid;
  logic signed [PW-1:0]     s1_p;
  logic signed [PW-1:0]     s1_old;
  logic [CW-1:0]            s1_ch;
  logic                     s1_primed;

  logic signed [AW-1:0]     acc  [CHANNELS];
  logic [PTRW-1:0]          wptr [CHANNELS];
  logic [FW-1:0]            fill [CHANNELS];

  logic signed [PW-1:0]     prod;
  logic [FW-1:0]            fill_cur, fill_next;
  logic [CW+PTRW-1:0]       hist_cat;
  logic [RAW-1:0]           hist_addr;
  logic [PW-1:0]            hist_rdata;
  logic                     hist_en;

  logic signed [AW-1:0]     acc_next, shifted;
  logic signed [EW-1:0]     sh_ext;
  logic signed [OUT_W-1:0]  s_next;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~clr;
  assign accept   = in_valid & in_ready;
  assign ch_ok    = (32'(in_ch) < CHANNELS);

  assign prod = PW'(s0_a) * PW'(s0_b);

  // Channel-major layout: slot = ch*DEPTH + ptr, DEPTH being a power of two.
  assign hist_cat  = {s0_ch, wptr[s0_ch]};
  assign hist_addr = hist_cat[RAW-1:0];
  assign hist_en   = s0_valid & ~stall;
  assign s1_old    = hist_rdata;

  always_comb begin
    fill_cur  = fill[s0_ch];
    fill_next = (fill_cur == FW'(DEPTH)) ? fill_cur : fill_cur + FW'(1);
  end

  always_comb begin
    acc_next = acc[s1_ch] + AW'(s1_p) - AW'(s1_old);
    shifted  = acc_next >>> SHIFT;
    sh_ext   = EW'(shifted);
`ifdef CONV_WINDOW_SAT_EN
    if (sh_ext > EW'((longint'(1) <<< (OUT_W - 1)) - 1))
      s_next = OUT_W'((longint'(1) <<< (OUT_W - 1)) - 1);
    else if (sh_ext < -EW'(longint'(1) <<< (OUT_W - 1)))
      s_next = OUT_W'(-(longint'(1) <<< (OUT_W - 1)));
    else
      s_next = OUT_W'(sh_ext);
`else
    s_next = OUT_W'(sh_ext);
`endif
  end

  conv_hist_ram #(
    .WIDTH   (PW),
    .ENTRIES (CHANNELS * DEPTH)
  ) u_hist (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .we    (hist_en),
    .waddr (hist_addr),
    .wdata (prod),
    .re    (hist_en),
    .raddr (hist_addr),
    .rdata (hist_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      s0_valid   <= 1'b0;
      s0_a       <= '0;
      s0_b       <= '0;
      s0_ch      <= '0;
      s1_valid   <= 1'b0;
      s1_p       <= '0;
      s1_ch      <= '0;
      s1_primed  <= 1'b0;
      out_valid  <= 1'b0;
      S          <= '0;
      out_ch     <= '0;
      out_primed <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]  <= '0;
        wptr[i] <= '0;
        fill[i] <= '0;
      end
    end else if (!stall) begin
      // Out-of-range channels are handshaken but never enter the pipe.
      s0_valid <= accept & ch_ok;
      if (accept) begin
        s0_a  <= A;
        s0_b  <= B;
        s0_ch <= in_ch;
      end

      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_p          <= prod;
        s1_ch         <= s0_ch;
        s1_primed     <= (fill_next == FW'(DEPTH));
        wptr[s0_ch]   <= wptr[s0_ch] + PTRW'(1);
        fill[s0_ch]   <= fill_next;
      end

      out_valid <= s1_valid;
      if (s1_valid) begin
        acc[s1_ch] <= acc_next;
        S          <= s_next;
        out_ch     <= s1_ch;
        out_primed <= s1_primed;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac: directed scenarios plus random traffic against a windowed-sum model.
module tb_conv_window_mac;
  localparam int DATA_W   = 12;
  localparam int DEPTH    = 8;
  localparam int CHANNELS = 2;
  localparam int OUT_W    = 16;
  localparam int SHIFT    = 0;
  localparam int CW       = 1;
`ifdef CONV_WINDOW_SAT_EN
  localparam longint BIG_EXP = 32767;
`else
  localparam longint BIG_EXP = 0;
`endif

  logic clk = 1'b0;
  logic reset, clr, in_valid, in_ready, out_valid, out_ready, out_primed;
  logic [CW-1:0] in_ch, out_ch;
  logic signed [DATA_W-1:0] A, B;
  logic signed [OUT_W-1:0] S;

  conv_window_mac #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .S(S), .out_primed(out_primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint s;
    longint ch;
    longint primed;
  } exp_t;

  exp_t   exp_q[$];
  longint prods [CHANNELS][2048];
  int     cnt [CHANNELS];
  int     checks = 0;
  int     errors = 0;
  longint last_s = 0;
  longint last_primed = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint narrow(input longint v);
    longint sh;
    logic signed [OUT_W-1:0] w;
    sh = v >>> SHIFT;
`ifdef CONV_WINDOW_SAT_EN
    if (sh > (longint'(1) <<< (OUT_W - 1)) - 1) return (longint'(1) <<< (OUT_W - 1)) - 1;
    if (sh < -(longint'(1) <<< (OUT_W - 1))) return -(longint'(1) <<< (OUT_W - 1));
    return sh;
`else
    w = OUT_W'(sh);
    return longint'(w);
`endif
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int c = 0; c < CHANNELS; c++) cnt[c] = 0;
  endtask

  // Result = sum of the most recent DEPTH accepted products of that channel.
  task automatic model_push(input int ch, input longint p);
    longint sum;
    exp_t e;
    int lo;
    prods[ch][cnt[ch]] = p;
    cnt[ch]++;
    sum = 0;
    lo = (cnt[ch] > DEPTH) ? cnt[ch] - DEPTH : 0;
    for (int j = lo; j < cnt[ch]; j++) sum += prods[ch][j];
    e.s = narrow(sum);
    e.ch = ch;
    e.primed = (cnt[ch] >= DEPTH) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    logic rst_s, clr_s, acc_s, xfer_s, stall_s, prim_s;
    logic [CW-1:0] ich_s, och_s;
    logic signed [DATA_W-1:0] a_s, b_s;
    logic signed [OUT_W-1:0] s_s;
    exp_t e;
    @(negedge clk);
    rst_s = reset;
    clr_s = clr;
    if (!rst_s) chk("in_ready", in_ready, (!(out_valid && !out_ready) && !clr) ? 1 : 0);
    acc_s   = in_valid & in_ready & ~rst_s & ~clr_s;
    xfer_s  = out_valid & out_ready & ~rst_s & ~clr_s;
    stall_s = out_valid & ~out_ready & ~rst_s & ~clr_s;
    ich_s = in_ch; a_s = A; b_s = B;
    s_s = S; och_s = out_ch; prim_s = out_primed;
    @(posedge clk);
    #1;
    if (rst_s || clr_s) begin
      model_clear();
    end else begin
      if (xfer_s) begin
        chk("out_has_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("S", s_s, e.s);
          chk("out_ch", och_s, e.ch);
          chk("out_primed", prim_s, e.primed);
          last_s = s_s;
          last_primed = prim_s;
        end
      end
      if (stall_s) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_S", S, s_s);
        chk("stall_ch", out_ch, och_s);
      end
      if (acc_s && int'(ich_s) < CHANNELS)
        model_push(int'(ich_s), longint'(a_s) * longint'(b_s));
    end
  endtask

  task automatic send(input int ch, input int a, input int b);
    in_valid = 1'b1;
    in_ch = CW'(ch);
    A = DATA_W'(a);
    B = DATA_W'(b);
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ch = '0; A = '0; B = '0; out_ready = 1'b1;
    model_clear();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_S", S, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_primed", out_primed, 0);
    chk("rst_in_ready", in_ready, 1);

    // Constant 3*5 on ch0: ramp 15..120 then hold, latency two edges.
    for (int i = 0; i < 10; i++) begin
      send(0, 3, 5);
      tick();
      if (i == 0) chk("lat_edge_n", out_valid, 0);
      if (i == 1) chk("lat_edge_n1", out_valid, 0);
      if (i == 2) chk("lat_edge_n2", out_valid, 1);
      if (i == 2) chk("lat_first_S", S, 15);
    end
    drain(4);
    chk("ramp_last_S", last_s, 120);
    chk("ramp_last_primed", last_primed, 1);

    // Full-scale negative operands.
    in_valid = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(0, -2048, -2048);
      tick();
    end
    drain(4);
    chk("fullscale_S", last_s, BIG_EXP);

    // Interleaved channels.
    in_valid = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) send(0, 1, 1);
      else send(1, 2, -3);
      tick();
    end
    drain(4);
    chk("interleave_last_S", last_s, -36);

    // Backpressure window in the middle of a stream.
    for (int i = 0; i < 16; i++) begin
      send(1, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
      out_ready = (i >= 4 && i < 9) ? 1'b0 : 1'b1;
      tick();
    end
    drain(5);
    chk("stall_pending", exp_q.size(), 0);

    // clr after five samples, then three more.
    for (int i = 0; i < 5; i++) begin
      send(0, 1, 1);
      tick();
    end
    in_valid = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(0, 1, 1);
      tick();
    end
    drain(4);
    chk("clr_last_S", last_s, 3);
    chk("clr_last_primed", last_primed, 0);

    // Reset in the middle of a stream.
    for (int i = 0; i < 3; i++) begin
      send(1, 7, 9);
      tick();
    end
    in_valid = 1'b0; reset = 1'b1;
    tick();
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_S", S, 0);
    reset = 1'b0;
    tick();
    chk("rst_mid_idle_valid", out_valid, 0);

    // Random traffic with random backpressure and occasional clr.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ch     = CW'($urandom_range(0, 1));
      A         = DATA_W'($urandom);
      B         = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 99) == 0);
      tick();
    end
    clr = 1'b0;
    drain(6);
    chk("final_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_mac.md
CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 Parameter DATA_W, default 12: signed two's-complement width of each input operand.
REQ-002 Parameter DEPTH, default 8: window length in samples; power of two, 2..256.
REQ-003 Parameter CHANNELS, default 2: number of independent time-multiplexed channels; 1..16.
REQ-004 Parameter OUT_W, default 16: signed output width.
REQ-005 Parameter SHIFT, default 0: right arithmetic shift applied to the accumulator before output.
REQ-006 clk  input  1  sole clock; all logic rising-edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 clr  input  1  synchronous clear of all channel state; not a reset.
REQ-009 in_valid  input  1  sample offered.
REQ-010 in_ready  output  1  sample accepted when in_valid & in_ready.
REQ-011 in_ch  input  $clog2(CHANNELS) (min 1)  channel of offered sample.
REQ-012 A, B  input  DATA_W each  signed operands.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_ch  output  as in_ch  channel of result.
REQ-016 S  output  OUT_W  signed windowed sum of products.
REQ-017 out_primed  output  1  channel has received at least DEPTH samples since reset/clr.

Function
REQ-018 Product P = A*B SHALL be full precision, PW = 2*DATA_W bits signed; accumulator AW = PW + log2(DEPTH) bits signed, never overflows.
REQ-019 Per channel c, S SHALL equal (sum of the last DEPTH accepted products of c, missing entries = 0) >>> SHIFT, then narrowed per REQ-030.
REQ-020 Pipeline: stage 1 registers P, channel, and the oldest history entry of that channel, then writes P into that slot; stage 2 updates acc[c] <= acc[c] + P - oldest and registers output.
REQ-021 Latency: result of a sample accepted at edge N SHALL be presented with out_valid=1 after edge N+2; throughput one sample per cycle, including back-to-back same channel.
REQ-022 stall = out_valid & ~out_ready; in_ready = ~stall & ~clr; while stall, all pipeline registers, history, pointers and outputs SHALL hold.
REQ-023 out_valid SHALL deassert after a transfer if no new result enters stage 2; out_ch, S, out_primed stable while out_valid & ~out_ready.
REQ-024 Per channel write pointer wraps DEPTH-1 -> 0; per channel fill counter saturates at DEPTH; out_primed = (fill count after this sample == DEPTH).
REQ-025 in_ch >= CHANNELS: sample SHALL be accepted and discarded, no state change, no output.
REQ-026 clr: zeroes all acc, history, pointers and fill counters, discards stage-1 and the output register (out_valid=0) in the same edge; in_ready=0 during clr.

Reset
REQ-027 reset SHALL override clr and all inputs; after reset out_valid=0, S=0, out_ch=0, out_primed=0, in_ready=1 (once reset and clr low).
REQ-028 All history entries, accumulators, pointers and fill counters SHALL be zero after reset; reset asserted mid-stream discards all in-flight data.

Configuration
REQ-029 Macro CONV_WINDOW_SAT_EN selects output narrowing.
REQ-030 Defined: shifted value outside OUT_W range SHALL clamp to 2^(OUT_W-1)-1 or -2^(OUT_W-1). Undefined: SHALL take the low OUT_W bits (wrap).

Structure
REQ-031 Package conv_pkg SHALL hold width functions (product width, accumulator width) and the channel-index width helper.
REQ-032 History storage SHALL be sub-module conv_hist_ram: CHANNELS*DEPTH x PW, one read and one write per cycle, same-address read returns old data.

Verification (DATA_W=12, DEPTH=8, CHANNELS=2, OUT_W=16, SHIFT=0)
REQ-033 Ch0, A=3,B=5 for 10 beats, out_ready=1 -> S=15,30,...,120,120,120; out_primed=1 from 8th result; latency 2.
REQ-034 A=B=-2048 ch0 x8 -> acc=33554432; SAT_EN: S=32767; without: S=0.
REQ-035 Interleave ch0 A=1,B=1 and ch1 A=2,B=-3 -> ch0 results 1,2,3...; ch1 -6,-12,-18...; no cross-talk.
REQ-036 out_ready=0 for 5 cycles under streaming -> in_ready=0 within cycle, S/out_ch held, no sample lost or duplicated after release.
REQ-037 clr after 5 samples of A=B=1 on ch0, then 3 more -> outputs 1,2,3 and out_primed=0; reset mid-stream -> out_valid=0 next cycle.
